sat_counter: RTL and testbench
==============================

SAT_COUNTER -- requirements
Module: sat_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter and count_max bit width, minimum 4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 clear  input  1  synchronous clear of count to 0.
REQ-005 enable  input  1  count-enable; when low, count holds.
REQ-006 up_down_n  input  1  direction: 1 counts up, 0 counts down.
REQ-007 step_size  input  3  step encoding; effective step = step_size + 1 (range 1..8).
REQ-008 count_max  input  WIDTH  upper saturation limit, unsigned, may change at any cycle.
REQ-009 count  output  WIDTH  registered counter value, unsigned.
REQ-010 count_max_reached  output  1  high when count == count_max.
REQ-011 count_zero_reached  output  1  high when count == 0.

Function
REQ-012 Per-edge priority: rst (async) > clear > enable > hold.
REQ-013 clear = 1 SHALL load count = 0 on the next edge regardless of enable, direction or step.
REQ-014 enable = 0 and clear = 0 SHALL hold count unchanged.
REQ-015 Up (enable = 1, up_down_n = 1): if count >= count_max, next = count_max; else if count + step >= count_max, next = count_max; else next = count + step.
REQ-016 Up-count sum SHALL be computed at WIDTH+1 bits; no wrap-around is permitted, even with count_max near 2^WIDTH-1.
REQ-017 Count above count_max (count_max lowered at runtime) with up enabled SHALL clamp to count_max in one cycle.
REQ-018 Down (enable = 1, up_down_n = 0): if count <= step, next = 0; else next = count - step; never underflows.
REQ-019 Down-count ignores count_max; a value above count_max decrements normally.
REQ-020 step_size, up_down_n and count_max are sampled at each edge; changes take effect on the same edge, with no pipeline delay.
REQ-021 count_max_reached and count_zero_reached SHALL be combinational compares of the registered count against count_max and 0.
REQ-022 With count_max = 0, both flags are high while count = 0.
REQ-023 count update latency: one clock cycle from input sample to new count.

Reset
REQ-024 rst high SHALL asynchronously force count = 0, regardless of clock.
REQ-025 During reset, count_zero_reached = 1 and count_max_reached = (count_max == 0).
REQ-026 Reset deassertion mid-operation SHALL resume normal counting from 0 on the first following edge.

Structure
REQ-027 No shared package is required; WIDTH is the only parameter.
REQ-028 Next-state arithmetic SHALL be a combinational sub-module sat_counter_next, with inputs count, count_max, step, up_down_n and output next_count.
REQ-029 Top level SHALL hold the single WIDTH-bit register, the priority mux and the flag compares.

Verification
REQ-030 Up saturation: count_max = 20, step_size = 0, enable = 1, 25 cycles from 0 -> count 1..20, then holds 20; count_max_reached high from count = 20.
REQ-031 Clear priority: from count 20, clear = 1 with enable = 1 -> count = 0 next edge, zero flag high; 2 more cycles -> count 2.
REQ-032 Step 4 up: from count 2, step_size = 3 -> 6, 10, 14, 18, 20, then holds 20.
REQ-033 Down step 2: from count 20, up_down_n = 0, step_size = 1 -> 18, 16, ..., 2, 0, then holds 0; count_zero_reached high at 0.
REQ-034 Enable gating and step 8: enable = 0 for 5 cycles -> count frozen; then clear, up, step_size = 7 -> 8, 16, 20, hold 20.
REQ-035 Async reset and overflow: rst pulsed between edges -> count 0 immediately; count_max = 254, count 250, step 8 up -> count 254, no wrap.

Source files
------------

// File: rtl/sat_counter_pkg.sv
// Shared constants and helpers for the saturating up/down counter.
//   STEP_SIZE_W : width of the encoded step_size input
//   STEP_W      : width of the decoded step (1..8)
//   MIN_WIDTH   : smallest supported counter width
package sat_counter_pkg;

  localparam int unsigned STEP_SIZE_W = 3;
  localparam int unsigned STEP_W      = STEP_SIZE_W + 1;
  localparam int unsigned MIN_WIDTH   = 4;

  // Encoded step_size 0..7 maps to an effective step of 1..8.
  function automatic logic [STEP_W-1:0] decode_step(input logic [STEP_SIZE_W-1:0] step_size);
    return STEP_W'(step_size) + STEP_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Combinational next-value arithmetic for the saturating counter.
// Ports:
//   count      : current registered count
//   count_max  : upper saturation limit (up direction only)
//   step       : decoded step, 1..8
//   up_down_n  : 1 = count up, 0 = count down
//   next_count : saturated next value
module sat_counter_next
  import sat_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  count_max,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down_n,
  output logic [WIDTH-1:0]  next_count
);

  localparam int unsigned SUM_W = WIDTH + 1;

  // One extra bit so count + step can never wrap past count_max.
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] step_w;

  assign sum    = {1'b0, count} + SUM_W'(step);
  assign step_w = WIDTH'(step);

  always_comb begin
    next_count = count;
    if (up_down_n) begin
      // A count above a lowered count_max also clamps here.
      if ((count >= count_max) || (sum >= {1'b0, count_max})) begin
        next_count = count_max;
      end else begin
        next_count = sum[WIDTH-1:0];
      end
    end else begin
      // Down direction ignores count_max and floors at zero.
      if (count <= step_w) begin
        next_count = '0;
      end else begin
        next_count = count - step_w;
      end
    end
  end

endmodule

// File: rtl/sat_counter.sv
// Saturating up/down counter with programmable step and upper limit.
// Ports:
//   clk, rst           : clock and asynchronous active-high reset
//   clear              : synchronous clear to zero (beats enable)
//   enable             : count enable; count holds when low
//   up_down_n          : 1 = up, 0 = down
//   step_size          : step encoding, effective step = step_size + 1
//   count_max          : upper saturation limit, may change any cycle
//   count              : registered counter value
//   count_max_reached  : count == count_max (combinational compare)
//   count_zero_reached : count == 0 (combinational compare)
// WIDTH must be at least MIN_WIDTH so a step of 8 fits in the counter.
module sat_counter
  import sat_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   up_down_n,
  input  logic [STEP_SIZE_W-1:0] step_size,
  input  logic [WIDTH-1:0]       count_max,
  output logic [WIDTH-1:0]       count,
  output logic                   count_max_reached,
  output logic                   count_zero_reached
);

  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  next_count;

  assign step = decode_step(step_size);

  sat_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count      (count),
    .count_max  (count_max),
    .step       (step),
    .up_down_n  (up_down_n),
    .next_count (next_count)
  );

  // Counter register: reset > clear > enable > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= next_count;
    end
  end

  assign count_max_reached  = (count == count_max);
  assign count_zero_reached = (count == '0);

endmodule

// File: tb/tb_sat_counter.sv
// Self-checking bench for sat_counter: directed scenarios followed by
// randomized traffic, all checked against a min/max reference model.
module tb_sat_counter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         enable;
  logic         up_down_n;
  logic [2:0]   step_size;
  logic [W-1:0] count_max;
  logic [W-1:0] count;
  logic         count_max_reached;
  logic         count_zero_reached;

  int total = 0;
  int bad   = 0;
  int ref_cnt = 0;

  sat_counter #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .clear              (clear),
    .enable             (enable),
    .up_down_n          (up_down_n),
    .step_size          (step_size),
    .count_max          (count_max),
    .count              (count),
    .count_max_reached  (count_max_reached),
    .count_zero_reached (count_zero_reached)
  );

  always #5 clk = ~clk;

  // Reference: up = min(c + s, max), down = max(c - s, 0).
  function automatic int model_next(int c, int m, bit clr, bit en, bit up, int ss);
    int s;
    s = ss + 1;
    if (clr) return 0;
    if (!en) return c;
    if (up) return (c + s < m) ? c + s : m;
    return (c > s) ? c - s : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(ref_cnt));
    check({tag, ".max_flag"}, 32'(count_max_reached), 32'(ref_cnt == int'(count_max)));
    check({tag, ".zero_flag"}, 32'(count_zero_reached), 32'(ref_cnt == 0));
  endtask

  // Inputs are driven just after a rising edge; the model uses the values
  // that will be sampled on the next edge.
  task automatic tick(input string tag);
    ref_cnt = model_next(ref_cnt, int'(count_max), clear, enable, up_down_n, int'(step_size));
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    ref_cnt = 0;
    check_state(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b0; up_down_n = 1'b1;
    step_size = 3'd0; count_max = '0;
    #3;
    check("reset.count", 32'(count), 32'd0);
    check("reset.zero_flag", 32'(count_zero_reached), 32'd1);
    check("reset.max_flag_max0", 32'(count_max_reached), 32'd1);
    count_max = 8'd20;
    #1;
    check("reset.max_flag_max20", 32'(count_max_reached), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_cnt = 0;

    // Up saturation at 20, step 1.
    enable = 1'b1;
    repeat (25) tick("up_sat");
    check("up_sat.final", 32'(count), 32'd20);

    // Clear beats enable.
    clear = 1'b1;
    tick("clear");
    check("clear.zero", 32'(count), 32'd0);
    clear = 1'b0;
    tick("after_clear");
    tick("after_clear");
    check("after_clear.two", 32'(count), 32'd2);

    // Step 4 up to saturation.
    step_size = 3'd3;
    repeat (7) tick("step4");
    check("step4.final", 32'(count), 32'd20);

    // Down by 2 to zero, then hold at zero.
    up_down_n = 1'b0;
    step_size = 3'd1;
    repeat (12) tick("down2");
    check("down2.final", 32'(count), 32'd0);

    // Enable gating, then step 8 from a clear.
    up_down_n = 1'b1;
    step_size = 3'd0;
    repeat (3) tick("pre_gate");
    enable = 1'b0;
    repeat (5) tick("gated");
    check("gated.frozen", 32'(count), 32'd3);
    clear = 1'b1;
    tick("clear2");
    clear = 1'b0;
    enable = 1'b1;
    step_size = 3'd7;
    repeat (4) tick("step8");
    check("step8.final", 32'(count), 32'd20);

    // Lowered limit clamps in one cycle; down ignores the limit.
    count_max = 8'd10;
    step_size = 3'd0;
    tick("clamp");
    check("clamp.value", 32'(count), 32'd10);
    count_max = 8'd5;
    up_down_n = 1'b0;
    tick("down_above_max");
    check("down_above_max.value", 32'(count), 32'd9);

    // Async reset between edges, then resume from zero.
    up_down_n = 1'b1;
    count_max = 8'd20;
    tick("pre_rst");
    async_reset_pulse("async_rst");
    tick("post_rst");
    check("post_rst.one", 32'(count), 32'd1);

    // No wrap near the top of the range.
    count_max = 8'd254;
    clear = 1'b1;
    tick("ovf_clear");
    clear = 1'b0;
    step_size = 3'd7;
    repeat (31) tick("ovf_climb");
    step_size = 3'd1;
    tick("ovf_250");
    check("ovf.250", 32'(count), 32'd250);
    step_size = 3'd7;
    tick("ovf_sat");
    check("ovf.254", 32'(count), 32'd254);
    tick("ovf_hold");
    count_max = 8'd255;
    clear = 1'b1;
    tick("ovf255_clear");
    clear = 1'b0;
    repeat (33) tick("ovf255");
    check("ovf255.final", 32'(count), 32'd255);

    // count_max = 0 with count = 0: both flags high.
    clear = 1'b1;
    count_max = '0;
    tick("max0");
    check("max0.both_flags", 32'({count_max_reached, count_zero_reached}), 32'd3);
    clear = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom % 16) == 0;
      enable    = ($urandom % 4) != 0;
      up_down_n = 1'($urandom % 2);
      step_size = 3'($urandom % 8);
      if (($urandom % 8) == 0) begin
        count_max = (($urandom % 2) == 0) ? 8'($urandom) : 8'(8'd255 - 8'($urandom % 4));
      end
      if (($urandom % 50) == 0) async_reset_pulse("rand_rst");
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
